// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - quadrature A/B synchroniser, glitch filter and x4 step/dir decoder
module quadrature_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int INIT_CYC = SYNC_STAGES + FILT_LEN;
    localparam int CNT_W    = $clog2(FILT_LEN + 1);
    localparam int INIT_W   = $clog2(INIT_CYC + 1);
    localparam logic [CNT_W-1:0]  FILT_MAX  = CNT_W'(FILT_LEN - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    state_t                   state_q, state_d;
    logic [INIT_W-1:0]        init_cnt_q, init_cnt_d;

    // Index 1 is phase A, index 0 is phase B, so {A,B} packs as a 2-bit state.
    logic [SYNC_STAGES-1:0]   sync_q [2];
    logic [SYNC_STAGES-1:0]   sync_d [2];
    logic [CNT_W-1:0]         cnt_q  [2];
    logic [CNT_W-1:0]         cnt_d  [2];
    logic [1:0]               filt_q, filt_d;
    logic [1:0]               prev_q, prev_d;
    logic [1:0]               raw, synced, delta;
    logic                     tracking;
    logic                     step_q, step_d;
    logic                     dir_q, dir_d;
    logic                     err_q, err_d;
    logic [ERR_W-1:0]         err_count_q, err_count_d;

    assign raw       = {a_in, b_in};
    assign synced    = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    // Decoding only happens while tracking and enabled; a low en_in silences outputs at once.
    assign tracking  = (state_q == ST_TRACK) && en_in;
    assign delta     = prev_q ^ filt_q;

    assign step      = step_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign err_count = err_count_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // FSM next state: INIT waits for the sync chain and filter window to fill before tracking
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (!en_in) begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
        end else if (state_q == ST_INIT) begin
            if (init_cnt_q == INIT_LAST) begin
                state_d    = ST_TRACK;
                init_cnt_d = '0;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end
    end

    // FSM outputs and datapath: synchronise, filter, decode, count errors
    always_comb begin
        filt_d      = filt_q;
        prev_d      = prev_q;
        step_d      = 1'b0;
        err_d       = 1'b0;
        dir_d       = dir_q;
        err_count_d = err_count_q;
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            cnt_d[i]  = '0;
        end
        if (!tracking) begin
            // Filter bypassed: adopt the synced levels so tracking starts with no pending edge.
            filt_d = synced;
            prev_d = synced;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (synced[i] != filt_q[i]) begin
                    if (cnt_q[i] == FILT_MAX) begin
                        filt_d[i] = synced[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
            prev_d = filt_q;
            step_d = (delta == 2'b01) || (delta == 2'b10);
            err_d  = (delta == 2'b11);
            // Forward (00->10->11->01) exactly when the new A differs from the old B.
            if (step_d) begin
                dir_d = prev_q[0] ^ filt_q[1];
            end
        end
        if (err_d && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            filt_q      <= '0;
            prev_q      <= '0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            filt_q      <= filt_d;
            prev_q      <= prev_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - self-checking bench for quadrature_decoder
module tb_quadrature_decoder;

    localparam int SS  = 2;
    localparam int FL  = 4;
    localparam int LAT = SS + FL + 1;

    logic       clk = 1'b0;
    logic       rst, en_in, a_in, b_in;
    logic       step, dir, err;
    logic [7:0] err_count;
    logic       step2, dir2, err2;
    logic [1:0] err_count2;

    quadrature_decoder #(.SYNC_STAGES(SS), .FILT_LEN(FL), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en_in(en_in), .a_in(a_in), .b_in(b_in),
        .step(step), .dir(dir), .err(err), .err_count(err_count)
    );

    quadrature_decoder #(.SYNC_STAGES(SS), .FILT_LEN(FL), .ERR_W(2)) dut_e2 (
        .clk(clk), .rst(rst), .en_in(en_in), .a_in(a_in), .b_in(b_in),
        .step(step2), .dir(dir2), .err(err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: position of {A,B} on the forward cycle 00->10->11->01.
    int         pos_of [4] = '{0, 3, 1, 2};
    logic [1:0] ab_of  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] m_ab;
    logic       m_dir;
    int         m_errs;

    // 0 = none, 1 = forward, 2 = illegal, 3 = reverse
    function automatic int kind(input logic [1:0] p, input logic [1:0] n);
        return (pos_of[n] - pos_of[p] + 4) % 4;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_move(input logic [1:0] ab, output int k);
        k = kind(m_ab, ab);
        if (k == 1) m_dir = 1'b1;
        else if (k == 3) m_dir = 1'b0;
        else if (k == 2) m_errs++;
        m_ab = ab;
    endtask

    int   o_step, o_err, o_first_step, o_first_err, o_diff;
    logic o_dir;

    task automatic observe(input int n);
        o_step = 0; o_err = 0; o_first_step = -1; o_first_err = -1; o_diff = 0;
        o_dir = dir;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                o_step++;
                if (o_first_step < 0) o_first_step = i;
                o_dir = dir;
            end
            if (err === 1'b1) begin
                o_err++;
                if (o_first_err < 0) o_first_err = i;
            end
            if (step2 !== step || err2 !== err || dir2 !== dir) o_diff++;
        end
    endtask

    task automatic drive(input logic [1:0] ab, input int hold);
        a_in = ab[1];
        b_in = ab[0];
        observe(hold);
    endtask

    task automatic test_reset();
        rst = 1'b1; en_in = 1'b1; a_in = 1'b1; b_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({step, dir, err, err_count, step2, dir2, err2, err_count2} !== 14'd0) begin
            fails++;
            $display("FAIL reset_state: step=%b dir=%b err=%b cnt=%0d cnt2=%0d, required all 0",
                     step, dir, err, err_count, err_count2);
        end
        rst = 1'b0;
        observe(SS + FL + 6);
        checks++;
        if (o_step != 0 || o_err != 0) begin
            fails++;
            $display("FAIL init_quiet: steps=%0d errs=%0d, required 0 and 0", o_step, o_err);
        end
        m_ab = 2'b11; m_dir = 1'b0; m_errs = 0;
    endtask

    task automatic test_sequence(input string name, input logic [1:0] seq [], input int hold);
        int k;
        int es, ee;
        foreach (seq[j]) begin
            model_move(seq[j], k);
            drive(seq[j], hold);
            es = (k == 1 || k == 3) ? 1 : 0;
            ee = (k == 2) ? 1 : 0;
            checks++;
            if (o_step != es || o_err != ee || (es == 1 && o_first_step != LAT) ||
                (ee == 1 && o_first_err != LAT) || o_dir !== m_dir || dir !== m_dir ||
                o_diff != 0 || err_count !== 8'(sat(m_errs, 255)) ||
                err_count2 !== 2'(sat(m_errs, 3))) begin
                fails++;
                $display("FAIL %s[%0d]: step=%0d@%0d err=%0d@%0d dir=%b cnt=%0d cnt2=%0d diff=%0d, required step=%0d@%0d err=%0d dir=%b cnt=%0d cnt2=%0d",
                         name, j, o_step, o_first_step, o_err, o_first_err, o_dir, err_count,
                         err_count2, o_diff, es, LAT, ee, m_dir, sat(m_errs, 255), sat(m_errs, 3));
            end
        end
    endtask

    task automatic test_glitch(input int reps);
        int ph, len, s_tot, e_tot;
        logic [1:0] g;
        for (int r = 0; r < reps; r++) begin
            ph  = (r == 0) ? 1 : int'($urandom_range(0, 1));
            len = (r == 0) ? FL - 1 : int'($urandom_range(1, FL - 1));
            g = m_ab;
            g[ph] = ~g[ph];
            drive(g, len);
            s_tot = o_step; e_tot = o_err;
            drive(m_ab, 12);
            s_tot += o_step; e_tot += o_err;
            checks++;
            if (s_tot != 0 || e_tot != 0 || o_diff != 0) begin
                fails++;
                $display("FAIL glitch[%0d] ph=%0d len=%0d: steps=%0d errs=%0d, required 0 and 0",
                         r, ph, len, s_tot, e_tot);
            end
        end
        test_sequence("after_glitch", '{ab_of[(pos_of[m_ab] + 1) % 4]}, 10);
    endtask

    task automatic test_random(input int n);
        logic [1:0] seq [];
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 8) begin
                test_glitch(1);
            end else begin
                seq = new[1];
                if (r < 4)      seq[0] = ab_of[(pos_of[m_ab] + 1) % 4];
                else if (r < 7) seq[0] = ab_of[(pos_of[m_ab] + 3) % 4];
                else            seq[0] = ~m_ab;
                test_sequence("random", seq, int'($urandom_range(LAT + 1, LAT + 7)));
            end
        end
    endtask

    task automatic test_enable();
        logic [1:0] nb, nb2;
        int s_tot, e_tot;
        nb  = ab_of[(pos_of[m_ab] + 1) % 4];
        nb2 = ab_of[(pos_of[nb] + 1) % 4];
        drive(nb, 3);
        s_tot = o_step; e_tot = o_err;
        en_in = 1'b0;
        observe(3);
        s_tot += o_step; e_tot += o_err;
        en_in = 1'b1;
        drive(nb2, SS + FL + 8);
        s_tot += o_step; e_tot += o_err;
        checks++;
        if (s_tot != 0 || e_tot != 0 || dir !== m_dir) begin
            fails++;
            $display("FAIL enable_gap: steps=%0d errs=%0d dir=%b, required 0 0 dir=%b",
                     s_tot, e_tot, dir, m_dir);
        end
        m_ab = nb2;
        test_sequence("after_enable", '{ab_of[(pos_of[m_ab] + 1) % 4]}, 10);
    endtask

    task automatic test_async_reset();
        logic [1:0] nb;
        int k;
        nb = ab_of[(pos_of[m_ab] + 1) % 4];
        model_move(nb, k);
        drive(nb, LAT);
        checks++;
        if (step !== 1'b1 || dir !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_step: step=%b dir=%b, required 1 and 1", step, dir);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({step, dir, err, err_count, step2, dir2, err2, err_count2} !== 14'd0) begin
            fails++;
            $display("FAIL async_reset: step=%b dir=%b err=%b cnt=%0d cnt2=%0d, required all 0",
                     step, dir, err, err_count, err_count2);
        end
        @(negedge clk);
        rst = 1'b0;
        m_dir = 1'b0; m_errs = 0;
        observe(SS + FL + 6);
        test_sequence("post_reset", '{ab_of[(pos_of[m_ab] + 3) % 4]}, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequence("from_11", '{2'b01, 2'b00}, 10);
        test_sequence("forward", '{2'b10, 2'b11, 2'b01, 2'b00}, 10);
        test_sequence("reverse", '{2'b01, 2'b11, 2'b10}, 10);
        test_glitch(4);
        test_sequence("to_00", '{2'b00}, 10);
        test_sequence("err_first", '{2'b11}, 10);
        test_sequence("err_sat", '{2'b00, 2'b11, 2'b00, 2'b11}, 10);
        test_sequence("back_to_back", '{2'b01, 2'b00, 2'b10, 2'b00}, FL + SS + 1);
        test_random(40);
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
